// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder: FSM states, data/lane
// constants and the address range check.
package mem_responder_pkg;

    localparam int DATA_W = 32;
    localparam int LANES  = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // offset is the byte address minus BASE, computed in the port address width,
    // so addresses below BASE have already wrapped to a huge offset here.
    function automatic logic isInRange(input logic [63:0] offset, input int unsigned depth);
        return (offset >> 2) < {32'd0, depth};
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Synchronous single-port word store with per-lane byte write enables and a
// registered read port.
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = 10
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [LANES-1:0]  i_wmask,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_index,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (i_wmask[i]) begin
                    r_mem[i_index][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_index];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Load/store memory responder: one request at a time, byte-masked writes and
// word reads, response after a fixed LATENCY.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned          ADDR_W  = 32,
    parameter int unsigned          DEPTH   = 1024,
    parameter logic [ADDR_W-1:0]    BASE    = 'h8000_0000,
    parameter int unsigned          LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_wen,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [LANES-1:0]  i_req_wmask,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] o_resp_rdata,
    output logic              o_resp_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            r_state;
    state_t            w_nextState;
    logic [3:0]        r_count;
    logic [3:0]        w_nextCount;
    logic              r_err;
    logic              r_rdSel;
    logic              w_accept;
    logic              w_inRange;
    logic              w_respDone;
    logic [ADDR_W-1:0] w_offset;
    logic [IDX_W-1:0]  w_index;
    logic [DATA_W-1:0] w_arrayRdata;

    assign w_offset    = i_req_addr - BASE;
    assign w_index     = w_offset[IDX_W+1:2];
    assign w_inRange   = isInRange(64'(w_offset), DEPTH);
    assign o_req_ready = (r_state == IDLE) && i_rst_n;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_respDone  = (r_state == RESP) && i_resp_ready;

    // The memory is touched only on the accept edge, so a write is committed
    // even if the transaction is later dropped by reset.
    mem_responder_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_accept && i_req_wen && w_inRange),
        .i_wmask (i_req_wmask),
        .i_re    (w_accept && !i_req_wen && w_inRange),
        .i_index (w_index),
        .i_wdata (i_req_wdata),
        .o_rdata (w_arrayRdata)
    );

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextCount = 4'(LATENCY - 1);
                    w_nextState = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_nextCount = r_count - 4'd1;
                if (r_count == 4'd1) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                if (i_resp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_err   <= 1'b0;
            r_rdSel <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            if (w_accept) begin
                r_err   <= !w_inRange;
                r_rdSel <= w_inRange && !i_req_wen;
            end else if (w_respDone) begin
                r_err   <= 1'b0;
                r_rdSel <= 1'b0;
            end
        end
    end

    assign o_resp_valid = (r_state == RESP);
    assign o_resp_err   = (r_state == RESP) && r_err;
    assign o_resp_rdata = ((r_state == RESP) && r_rdSel) ? w_arrayRdata : '0;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's load/store port: accepts one request at a time over a valid/ready handshake.
- Performs a byte-masked write or a word read on an internal word array.
- Returns a response after a fixed, parameterised latency.
- Stands in for physical memory in simulation and on-chip SRAM; the load/store initiator does sign/zero extension, the responder only moves aligned words.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, data width; fixed at 32; byte lanes = DATA_W/8 = 4.
- DEPTH, 1024, number of 32-bit words stored.
- BASE, 32'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from request accept to resp_valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- req_wen  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_W  write data, lane-aligned.
- req_wmask  in  4  byte strobes; bit i enables byte i.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts response.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_err  out  1  address outside [BASE, BASE+4*DEPTH).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0. req_ready=1 as soon as rst_n is high. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept on a rising edge with req_valid=1.
  - Index = (req_addr-BASE)>>2.
  - In range and req_wen=1: commit every byte with req_wmask[i]=1 on that same edge; resp_rdata=0.
  - In range and req_wen=0: capture the word into a response register on that same edge.
  - Out of range: no memory access; resp_err=1, resp_rdata=0.
  - On accept, load counter=LATENCY-1; go to RESP if LATENCY==1, else WAIT.
- WAIT: req_ready=0; decrement counter each cycle; when counter reaches 1, go to RESP on the next edge.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable.
  - Leave on an edge with resp_ready=1: return to IDLE, clear resp_valid/resp_err/resp_rdata.
  - resp_ready low holds RESP indefinitely.
- Latency: a request accepted at edge k produces resp_valid=1 in the cycle following edge k+LATENCY-1, i.e. exactly LATENCY cycles after the accept cycle.
- Back-to-back: the cycle after a response handshake, req_ready=1 again. There is no response/request overlap; throughput is at most one transaction per LATENCY+1 cycles.
- wmask=0 on a write: no bytes change; a normal response is still returned.
- Read of a word written by the previous transaction returns the new data, since the write has committed.
- Reset mid-WAIT/RESP: the transaction is dropped and no response is issued. A write already committed at accept stays committed.
- req_valid while req_ready=0: ignored. The initiator must hold the request until accepted.
- Address arithmetic: unsigned 32-bit. Addresses below BASE wrap to a huge index and are flagged out of range.

Decomposition:
- Shared package holds:
  - state enum {IDLE, WAIT, RESP};
  - DATA_W and lane-count constants;
  - the in-range check expressed as a function of BASE/DEPTH.
- One natural sub-module: mem_responder_array, a synchronous single-port word array with 4-lane byte-write enable and registered read. The top holds the FSM, counter and response registers.

Test Plan:
1. Reset, then write 0xDEADBEEF to 0x80000010 with mask 4'hF, then read 0x80000010 -> resp_rdata=0xDEADBEEF, resp_err=0; each response exactly LATENCY=2 cycles after accept.
2. Write 0xFFFFFFFF to 0x80000020 (mask F), then 0x000000AB with mask 4'h1, then 0x00CD0000 with mask 4'h4; read -> 0xFFCDFFAB.
3. Read 0x7FFFFFFC and 0x80001000 (DEPTH=1024) -> resp_err=1, resp_rdata=0; a write to 0x80001000 leaves 0x80000000 unchanged.
4. Hold resp_ready=0 for 5 cycles in RESP -> resp_valid stays 1, data stable, req_ready=0 throughout. Raise resp_ready -> IDLE the next cycle, req_ready=1.
5. Accept a read, pull rst_n low during WAIT -> resp_valid=0 immediately (async), no response after release, req_ready=1 after release.
6. Sweep LATENCY=1 and LATENCY=15 builds -> resp_valid first seen 1 and 15 cycles after accept respectively; back-to-back requests accepted on the cycle after each response handshake.
